// File: rtl/zr_mem_pkg.sv
// Shared types and helpers for the zero-riscy data memory slave.
//   gnt_state_e : grant FSM state encoding
//   mem_resp_t  : one response-pipe entry {valid, rdata, err}
//   in_range()  : byte address window check against base and word-index width
package zr_mem_pkg;

  localparam int unsigned DefAddrWidth = 14;
  localparam logic [31:0] DefBaseAddr  = 32'h0001_0000;
  localparam int unsigned DefGntDelay  = 0;
  localparam int unsigned DefRespDelay = 1;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StWait = 1'b1
  } gnt_state_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] rdata;
    logic        err;
  } mem_resp_t;

  // 33-bit limit so a window ending at 4 GiB does not wrap to zero.
  function automatic logic in_range(input logic [31:0] addr, input logic [31:0] base,
                                    input int unsigned aw);
    logic [32:0] limit;
    limit = {1'b0, base} + (33'd4 << aw);
    return (addr >= base) && ({1'b0, addr} < limit);
  endfunction

endpackage

// File: rtl/zr_data_mem_if.sv
// LSU data bus (req/gnt/rvalid) between the core (master) and the memory (slave).
//   data_req_i/addr_i/we_i/be_i/wdata_i : request side, driven by the master
//   data_gnt_o/rvalid_o/rdata_o/err_o   : response side, driven by the slave
interface zr_data_mem_if;
  logic        data_req_i;
  logic [31:0] data_addr_i;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_wdata_i;
  logic        data_gnt_o;
  logic        data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        data_err_o;

  modport master (
    output data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
    input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o
  );

  modport slave (
    input  data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
    output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o
  );
endinterface

// File: rtl/zr_resp_pipe.sv
// Fixed-latency response delay line: Depth-deep shift register of mem_resp_t.
//   clk_i, rst_ni : clock, asynchronous active-low reset (flushes all entries)
//   resp_i        : entry captured on the grant edge
//   resp_o        : entry Depth cycles later, straight from the last flop
module zr_resp_pipe
  import zr_mem_pkg::*;
#(
  parameter int unsigned Depth = DefRespDelay
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  mem_resp_t resp_i,
  output mem_resp_t resp_o
);

  mem_resp_t [Depth-1:0] stage_q;
  mem_resp_t [Depth-1:0] stage_d;

  always_comb begin
    stage_d    = '0;
    stage_d[0] = resp_i;
    for (int i = 1; i < Depth; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign resp_o = stage_q[Depth-1];

endmodule

// File: rtl/zr_data_mem.sv
// Word-addressed data memory slave for the zero-riscy LSU.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   bus (slave)   : req/gnt/rvalid data bus; byte-enable writes, fixed-latency
//                   read data, err flagged for accesses outside the window
// Parameters: ADDR_WIDTH word-index bits, BASE_ADDR byte address of word 0,
// GNT_DELAY wait cycles before grant (0..7), RESP_DELAY grant-to-rvalid (1..4).
module zr_data_mem
  import zr_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DefAddrWidth,
  parameter logic [31:0] BASE_ADDR  = DefBaseAddr,
  parameter int unsigned GNT_DELAY  = DefGntDelay,
  parameter int unsigned RESP_DELAY = DefRespDelay
) (
  input logic          clk_i,
  input logic          rst_ni,
  zr_data_mem_if.slave bus
);

  localparam logic [2:0] GntDelayW = 3'(GNT_DELAY);

  gnt_state_e state_q, state_d;
  logic [2:0] wcnt_q, wcnt_d;
  logic       gnt;
  logic       gnt_ok;

  // Grant FSM: each grant returns to idle, so the wait count restarts per access.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    gnt     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (GNT_DELAY == 0) begin
          gnt = bus.data_req_i;
        end else if (bus.data_req_i) begin
          state_d = StWait;
          wcnt_d  = 3'd1;
        end
      end
      StWait: begin
        if (!bus.data_req_i) begin
          // Request withdrawn before grant: abandon it, no access.
          state_d = StIdle;
          wcnt_d  = '0;
        end else if (wcnt_q == GntDelayW) begin
          gnt     = 1'b1;
          state_d = StIdle;
          wcnt_d  = '0;
        end else begin
          wcnt_d = wcnt_q + 3'd1;
        end
      end
      default: begin
        state_d = StIdle;
        wcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Keep grant low while reset is held even if a master drives req.
  assign gnt_ok         = gnt && rst_ni;
  assign bus.data_gnt_o = gnt_ok;

  logic                  hit;
  logic [ADDR_WIDTH-1:0] idx;

  assign hit = in_range(bus.data_addr_i, BASE_ADDR, ADDR_WIDTH);
  assign idx = bus.data_addr_i[ADDR_WIDTH+1:2];

  // Byte-writable single-port array; contents survive reset.
  logic [31:0] mem_q [2**ADDR_WIDTH];

  always_ff @(posedge clk_i) begin
    if (gnt_ok && hit && bus.data_we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.data_be_i[b]) begin
          mem_q[idx][8*b +: 8] <= bus.data_wdata_i[8*b +: 8];
        end
      end
    end
  end

  mem_resp_t resp_in;
  mem_resp_t resp_out;

  always_comb begin
    resp_in = '0;
    if (gnt_ok) begin
      resp_in.valid = 1'b1;
      if (!hit) begin
        resp_in.err = 1'b1;
      end else if (!bus.data_we_i) begin
        resp_in.rdata = mem_q[idx];
      end
    end
  end

  zr_resp_pipe #(
    .Depth(RESP_DELAY)
  ) u_resp_pipe (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .resp_i(resp_in),
    .resp_o(resp_out)
  );

  assign bus.data_rvalid_o = resp_out.valid;
  assign bus.data_rdata_o  = resp_out.rdata;
  assign bus.data_err_o    = resp_out.err;

endmodule

// File: tb/tb_zr_data_mem.sv
// Directed bench for zr_data_mem with three parameterisations:
//   u_a : GNT_DELAY=0, RESP_DELAY=1 (defaults)
//   u_b : GNT_DELAY=3, RESP_DELAY=2
//   u_c : GNT_DELAY=0, RESP_DELAY=4
module tb_zr_data_mem;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  zr_data_mem_if bus_a ();
  zr_data_mem_if bus_b ();
  zr_data_mem_if bus_c ();

  zr_data_mem #(
    .ADDR_WIDTH(14), .BASE_ADDR(32'h0001_0000), .GNT_DELAY(0), .RESP_DELAY(1)
  ) u_a (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus_a)
  );

  zr_data_mem #(
    .ADDR_WIDTH(14), .BASE_ADDR(32'h0001_0000), .GNT_DELAY(3), .RESP_DELAY(2)
  ) u_b (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus_b)
  );

  zr_data_mem #(
    .ADDR_WIDTH(14), .BASE_ADDR(32'h0001_0000), .GNT_DELAY(0), .RESP_DELAY(4)
  ) u_c (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus_c)
  );

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %08h, want %08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] waddr(input int j);
    return 32'h0001_0000 + 32'(4 * j);
  endfunction

  // One isolated access on u_a: grant in cycle 0, response in cycle 1.
  task automatic access_a(input logic we, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wdata, input logic [31:0] exp_rdata,
                          input logic exp_err, input string tag);
    @(posedge clk); #1;
    bus_a.data_req_i   = 1'b1;
    bus_a.data_we_i    = we;
    bus_a.data_addr_i  = addr;
    bus_a.data_be_i    = be;
    bus_a.data_wdata_i = wdata;
    @(negedge clk);
    check_val({tag, " gnt"}, 32'(bus_a.data_gnt_o), 32'd1);
    check_val({tag, " rvalid early"}, 32'(bus_a.data_rvalid_o), 32'd0);
    @(posedge clk); #1;
    bus_a.data_req_i = 1'b0;
    bus_a.data_we_i  = 1'b0;
    @(negedge clk);
    check_val({tag, " rvalid"}, 32'(bus_a.data_rvalid_o), 32'd1);
    check_val({tag, " rdata"}, bus_a.data_rdata_o, exp_rdata);
    check_val({tag, " err"}, 32'(bus_a.data_err_o), 32'(exp_err));
  endtask

  logic [31:0] exp_d;
  logic        exp_v;

  initial begin
    bus_a.data_req_i = 1'b0; bus_a.data_we_i = 1'b0; bus_a.data_addr_i = '0;
    bus_a.data_be_i  = 4'hF; bus_a.data_wdata_i = '0;
    bus_b.data_req_i = 1'b0; bus_b.data_we_i = 1'b0; bus_b.data_addr_i = '0;
    bus_b.data_be_i  = 4'hF; bus_b.data_wdata_i = '0;
    bus_c.data_req_i = 1'b0; bus_c.data_we_i = 1'b0; bus_c.data_addr_i = '0;
    bus_c.data_be_i  = 4'hF; bus_c.data_wdata_i = '0;

    // Reset state
    #2;
    check_val("rst a gnt", 32'(bus_a.data_gnt_o), 32'd0);
    check_val("rst a rvalid", 32'(bus_a.data_rvalid_o), 32'd0);
    check_val("rst a rdata", bus_a.data_rdata_o, 32'd0);
    check_val("rst a err", 32'(bus_a.data_err_o), 32'd0);
    check_val("rst b rvalid", 32'(bus_b.data_rvalid_o), 32'd0);
    check_val("rst b err", 32'(bus_b.data_err_o), 32'd0);
    check_val("rst c rvalid", 32'(bus_c.data_rvalid_o), 32'd0);
    check_val("rst c rdata", bus_c.data_rdata_o, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Default config: full-word write / read-back, partial writes, range checks
    access_a(1'b1, 32'h0001_0010, 4'hF, 32'hDEAD_BEEF, 32'h0, 1'b0, "wr beef");
    access_a(1'b0, 32'h0001_0010, 4'h0, 32'h0, 32'hDEAD_BEEF, 1'b0, "rd beef");
    access_a(1'b1, 32'h0001_0020, 4'hF, 32'hFFFF_FFFF, 32'h0, 1'b0, "wr ones");
    access_a(1'b1, 32'h0001_0020, 4'b0100, 32'h00AA_0000, 32'h0, 1'b0, "wr byte2");
    access_a(1'b0, 32'h0001_0020, 4'hF, 32'h0, 32'hFFAA_FFFF, 1'b0, "rd partial");
    access_a(1'b1, 32'h0001_0020, 4'h0, 32'h1234_5678, 32'h0, 1'b0, "wr be0");
    access_a(1'b0, 32'h0001_0020, 4'hF, 32'h0, 32'hFFAA_FFFF, 1'b0, "rd after be0");
    access_a(1'b1, 32'h0001_0000, 4'hF, 32'h1122_3344, 32'h0, 1'b0, "wr word0");
    access_a(1'b0, 32'h0000_0FFC, 4'hF, 32'h0, 32'h0, 1'b1, "rd below");
    access_a(1'b1, 32'h0002_0000, 4'hF, 32'h5555_5555, 32'h0, 1'b1, "wr past end");
    access_a(1'b0, 32'h0001_0000, 4'hF, 32'h0, 32'h1122_3344, 1'b0, "rd word0 kept");
    access_a(1'b1, 32'h0001_FFFF, 4'hF, 32'hCAFE_F00D, 32'h0, 1'b0, "wr last");
    access_a(1'b0, 32'h0001_FFFC, 4'hF, 32'h0, 32'hCAFE_F00D, 1'b0, "rd last");

    // Latency sweep on u_b with req held: 4 writes then 4 reads, one grant per 4 cycles
    for (int cyc = 0; cyc < 38; cyc++) begin
      @(posedge clk); #1;
      if (cyc < 32) begin
        bus_b.data_req_i   = 1'b1;
        bus_b.data_we_i    = ((cyc / 4) < 4);
        bus_b.data_addr_i  = waddr((cyc / 4) % 4);
        bus_b.data_be_i    = 4'hF;
        bus_b.data_wdata_i = 32'hB0B0_0000 + 32'((cyc / 4) % 4);
      end else begin
        bus_b.data_req_i = 1'b0;
        bus_b.data_we_i  = 1'b0;
      end
      @(negedge clk);
      exp_v = (cyc < 32) && ((cyc % 4) == 3);
      check_val($sformatf("b gnt c%0d", cyc), 32'(bus_b.data_gnt_o), 32'(exp_v));
      exp_v = (cyc >= 5) && (((cyc - 5) % 4) == 0) && (((cyc - 5) / 4) < 8);
      check_val($sformatf("b rvalid c%0d", cyc), 32'(bus_b.data_rvalid_o), 32'(exp_v));
      if (exp_v) begin
        exp_d = (((cyc - 5) / 4) < 4) ? 32'h0 : 32'hB0B0_0000 + 32'(((cyc - 5) / 4) - 4);
        check_val($sformatf("b rdata c%0d", cyc), bus_b.data_rdata_o, exp_d);
      end
    end

    // Pipelined burst on u_c: 8 writes, 8 reads, then write/read of word 5 back-to-back
    for (int cyc = 0; cyc < 24; cyc++) begin
      @(posedge clk); #1;
      bus_c.data_be_i = 4'hF;
      if (cyc < 8) begin
        bus_c.data_req_i = 1'b1; bus_c.data_we_i = 1'b1;
        bus_c.data_addr_i = waddr(cyc); bus_c.data_wdata_i = 32'hC000_0000 + 32'(cyc);
      end else if (cyc < 16) begin
        bus_c.data_req_i = 1'b1; bus_c.data_we_i = 1'b0; bus_c.data_addr_i = waddr(cyc - 8);
      end else if (cyc == 16) begin
        bus_c.data_req_i = 1'b1; bus_c.data_we_i = 1'b1;
        bus_c.data_addr_i = waddr(5); bus_c.data_wdata_i = 32'h5A5A_5A5A;
      end else if (cyc == 17) begin
        bus_c.data_req_i = 1'b1; bus_c.data_we_i = 1'b0; bus_c.data_addr_i = waddr(5);
      end else begin
        bus_c.data_req_i = 1'b0; bus_c.data_we_i = 1'b0;
      end
      @(negedge clk);
      check_val($sformatf("c gnt c%0d", cyc), 32'(bus_c.data_gnt_o), 32'(cyc < 18));
      exp_v = (cyc >= 4) && (cyc < 22);
      check_val($sformatf("c rvalid c%0d", cyc), 32'(bus_c.data_rvalid_o), 32'(exp_v));
      if (exp_v) begin
        if ((cyc - 4) >= 8 && (cyc - 4) < 16) exp_d = 32'hC000_0000 + 32'(cyc - 12);
        else if ((cyc - 4) == 17)             exp_d = 32'h5A5A_5A5A;
        else                                  exp_d = 32'h0;
        check_val($sformatf("c rdata c%0d", cyc), bus_c.data_rdata_o, exp_d);
      end
    end

    // Reset mid-operation on u_c: write word 9, two reads in flight when reset hits
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(posedge clk); #1;
      bus_c.data_be_i = 4'hF;
      if (cyc == 0) begin
        bus_c.data_req_i = 1'b1; bus_c.data_we_i = 1'b1;
        bus_c.data_addr_i = waddr(9); bus_c.data_wdata_i = 32'h9999_0009;
      end else if (cyc < 3) begin
        bus_c.data_req_i = 1'b1; bus_c.data_we_i = 1'b0; bus_c.data_addr_i = waddr(cyc - 1);
      end else begin
        bus_c.data_req_i = 1'b0; bus_c.data_we_i = 1'b0;
      end
      @(negedge clk);
      if (cyc == 4) check_val("mid wr rvalid", 32'(bus_c.data_rvalid_o), 32'd1);
    end
    #1 rst_n = 1'b0;
    #1;
    check_val("mid rst rvalid", 32'(bus_c.data_rvalid_o), 32'd0);
    check_val("mid rst rdata", bus_c.data_rdata_o, 32'd0);
    check_val("mid rst err", 32'(bus_c.data_err_o), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      check_val($sformatf("post rst rvalid %0d", cyc), 32'(bus_c.data_rvalid_o), 32'd0);
    end
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(posedge clk); #1;
      bus_c.data_req_i  = (cyc == 0);
      bus_c.data_we_i   = 1'b0;
      bus_c.data_addr_i = waddr(9);
      @(negedge clk);
      if (cyc == 0) check_val("post rst gnt", 32'(bus_c.data_gnt_o), 32'd1);
      check_val($sformatf("post rst rd rvalid c%0d", cyc), 32'(bus_c.data_rvalid_o),
                32'(cyc == 4));
      if (cyc == 4) check_val("post rst rd rdata", bus_c.data_rdata_o, 32'h9999_0009);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
